// File: rtl/mul_div_unit_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
package mul_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } mul_div_f3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_div_state_t;

    function automatic logic f3_signed_a(input mul_div_f3_t f3);
        return (f3 == MD_MULH) || (f3 == MD_MULHSU) || (f3 == MD_DIV) || (f3 == MD_REM);
    endfunction

    function automatic logic f3_signed_b(input mul_div_f3_t f3);
        return (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
    endfunction

endpackage

// File: rtl/mul_div_unit_step.sv
// Combinational UNROLL-bit slice: shift-add multiply or restoring divide on {hi, lo}.
module mul_div_step #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned UNROLL = 1
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // mul: hi accumulates, multiplier shifts out of lo; div: dividend shifts out of lo, quotient shifts in
    always_comb begin
        sum = '0;
        hi  = hi_i;
        lo  = lo_i;
        for (int unsigned i = 0; i < UNROLL; i++) begin
            if (is_div_i) begin
                sum = {hi, lo[WIDTH-1]} - {1'b0, b_i};
                if (!sum[WIDTH]) begin
                    hi = sum[WIDTH-1:0];
                    lo = {lo[WIDTH-2:0], 1'b1};
                end else begin
                    hi = {hi[WIDTH-2:0], lo[WIDTH-1]};
                    lo = {lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                sum = {1'b0, hi} + (lo[0] ? {1'b0, b_i} : '0);
                hi  = sum[WIDTH:1];
                lo  = {sum[0], lo[WIDTH-1:1]};
            end
        end
        hi_o = hi;
        lo_o = lo;
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit with tagged valid/ready result port and flush.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned UNROLL = 1,
    parameter int unsigned TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  mul_div_f3_t       in_funct3,
    input  logic [WIDTH-1:0]  in_rs1,
    input  logic [WIDTH-1:0]  in_rs2,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int unsigned ITER  = WIDTH / UNROLL;
    localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    mul_div_state_t    state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WIDTH-1:0]  hi_q, lo_q, b_q;
    mul_div_f3_t       op_q;
    logic              sa_q, sb_q;
    logic [TAG_W-1:0]  tag_q;
    logic [WIDTH-1:0]  result_q;
    logic [TAG_W-1:0]  out_tag_q;
    logic              out_valid_q;
    logic              in_ready_q;

    logic [WIDTH-1:0]   hi_d, lo_d;
    logic [WIDTH-1:0]   result_d;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               special;
    logic [WIDTH-1:0]   special_res;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quot_s, rem_s;

    mul_div_step #(
        .WIDTH  (WIDTH),
        .UNROLL (UNROLL)
    ) u_step (
        .is_div_i (op_q[2]),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .b_i      (b_q),
        .hi_o     (hi_d),
        .lo_o     (lo_d)
    );

    always_comb begin
        neg_a = f3_signed_a(in_funct3) && in_rs1[WIDTH-1];
        neg_b = f3_signed_b(in_funct3) && in_rs2[WIDTH-1];
        mag_a = neg_a ? -in_rs1 : in_rs1;
        mag_b = neg_b ? -in_rs2 : in_rs2;

        special     = 1'b0;
        special_res = '0;
        if (in_funct3[2] && (in_rs2 == '0)) begin
            special     = 1'b1;
            special_res = in_funct3[1] ? in_rs1 : '1;
        end else if (((in_funct3 == MD_DIV) || (in_funct3 == MD_REM)) &&
                     (in_rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (in_rs2 == '1)) begin
            special     = 1'b1;
            special_res = in_funct3[1] ? '0 : in_rs1;
        end
    end

    // Sign fix on the final step output; zero magnitudes are never negated
    always_comb begin
        prod   = {hi_d, lo_d};
        prod_s = ((sa_q ^ sb_q) && (prod != '0)) ? -prod : prod;
        quot_s = ((sa_q ^ sb_q) && (lo_d != '0)) ? -lo_d : lo_d;
        rem_s  = (sa_q && (hi_d != '0)) ? -hi_d : hi_d;
        result_d = '0;
        case (op_q)
            MD_MUL:                        result_d = prod_s[WIDTH-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  result_d = prod_s[2*WIDTH-1:WIDTH];
            MD_DIV, MD_DIVU:               result_d = quot_s;
            MD_REM, MD_REMU:               result_d = rem_s;
            default:                       result_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            b_q         <= '0;
            op_q        <= MD_MUL;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            tag_q       <= '0;
            result_q    <= '0;
            out_tag_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (flush) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        if (special) begin
                            result_q    <= special_res;
                            out_tag_q   <= in_tag;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            hi_q    <= '0;
                            lo_q    <= mag_a;
                            b_q     <= mag_b;
                            op_q    <= in_funct3;
                            sa_q    <= neg_a;
                            sb_q    <= neg_b;
                            tag_q   <= in_tag;
                            cnt_q   <= '0;
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        result_q    <= result_d;
                        out_tag_q   <= tag_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = result_q;
    assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed RV32M vectors, back-pressure, flush and reset.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    mul_div_f3_t in_funct3 = MD_MUL;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_tag;

    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic        out_valid4;
    logic [31:0] out_result4;
    logic [4:0]  out_tag4;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32), .UNROLL(1), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

    mul_div_unit #(.WIDTH(32), .UNROLL(4), .TAG_W(5)) dut4 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_funct3(MD_MUL),
        .in_rs1(32'd7), .in_rs2(32'hFFFF_FFFD), .in_tag(5'd5),
        .out_valid(out_valid4), .out_ready(1'b1),
        .out_result(out_result4), .out_tag(out_tag4)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   acc_neg = 0;
    int   hs_cyc = 0;
    bit   seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Latency = posedges from the accept edge to the edge that captures out_valid
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready && !flush) acc_neg = cyc;
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_valid: got tag %0d result 0x%0h, required no output", out_tag, out_result);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        check("latency", 64'(cyc - acc_neg), 64'(q[0].lat));
                    end
                    if (out_ready && !flush) begin
                        check("result", 64'(out_result), 64'(q[0].res));
                        check("tag", 64'(out_tag), 64'(q[0].tag));
                        void'(q.pop_front());
                        seen   = 1'b0;
                        hs_cyc = cyc;
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge
    task automatic issue(input mul_div_f3_t f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] res, input int lat, input bit push);
        int n;
        in_valid  = 1'b1;
        in_funct3 = f3;
        in_rs1    = a;
        in_rs2    = b;
        in_tag    = tag;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            n_total++;
            $display("FAIL accept_timeout: tag %0d never accepted, required acceptance", tag);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push && n < 300) q.push_back('{res: res, tag: tag, lat: lat});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat4;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);

        issue(MD_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33, 1);
        issue(MD_MULH,   32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 33, 1);
        issue(MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 33, 1);
        issue(MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 33, 1);
        issue(MD_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd13, 32'h0000_0001, 33, 1);
        issue(MD_MULH,   32'hFFFF_FFFF,  32'd0,         5'd14, 32'h0000_0000, 33, 1);
        issue(MD_DIV,    32'hFFFF_FFF9,  32'd2,         5'd15, 32'hFFFF_FFFD, 33, 1);
        issue(MD_REM,    32'hFFFF_FFF9,  32'd2,         5'd16, 32'hFFFF_FFFF, 33, 1);
        issue(MD_DIVU,   32'hFFFF_FFFF,  32'd2,         5'd17, 32'h7FFF_FFFF, 33, 1);
        issue(MD_REMU,   32'd100,        32'd7,         5'd18, 32'd2,         33, 1);
        issue(MD_DIV,    32'd7,          32'hFFFF_FFFE, 5'd19, 32'hFFFF_FFFD, 33, 1);
        issue(MD_REM,    32'd7,          32'hFFFF_FFFE, 5'd20, 32'd1,         33, 1);
        issue(MD_DIV,    32'd5,          32'd0,         5'd21, 32'hFFFF_FFFF, 1,  1);
        issue(MD_REM,    32'd5,          32'd0,         5'd22, 32'd5,         1,  1);
        issue(MD_DIVU,   32'd5,          32'd0,         5'd23, 32'hFFFF_FFFF, 1,  1);
        issue(MD_REMU,   32'd5,          32'd0,         5'd24, 32'd5,         1,  1);
        issue(MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd25, 32'h8000_0000, 1,  1);
        issue(MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd26, 32'd0,         1,  1);
        drain();

        // Back-pressure: result held, no new accept, then back-to-back issue after handshake
        out_ready = 1'b0;
        issue(MD_DIVU, 32'd1000, 32'd10, 5'd27, 32'd100, 33, 1);
        while (!out_valid && (cyc - acc_neg) < 100) @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_result", 64'(out_result), 64'd100);
            check("bp_tag", 64'(out_tag), 64'd27);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(MD_MUL, 32'd6, 32'd7, 5'd28, 32'd42, 33, 1);
        check("b2b_accept_gap", 64'(acc_neg - hs_cyc), 64'd1);
        drain();

        // Flush at iteration 10
        issue(MD_MUL, 32'd123, 32'd456, 5'd9, 32'd0, 0, 0);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        issue(MD_MUL, 32'd3, 32'd4, 5'd11, 32'd12, 33, 1);
        drain();

        // Flush in IDLE drops a same-cycle request
        in_valid  = 1'b1;
        in_funct3 = MD_DIV;
        in_rs1    = 32'd5;
        in_rs2    = 32'd0;
        in_tag    = 5'd10;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("idle_flush_in_ready", 64'(in_ready), 64'd1);
        check("idle_flush_out_valid", 64'(out_valid), 64'd0);
        check("idle_flush_result_kept", 64'(out_result), 64'd12);
        repeat (5) @(posedge clk);
        #1;

        // Reset mid-BUSY
        issue(MD_MUL, 32'd55, 32'd66, 5'd12, 32'd0, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy_out_result", 64'(out_result), 64'd0);
        check("rst_busy_out_tag", 64'(out_tag), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        issue(MD_REMU, 32'd100, 32'd7, 5'd29, 32'd2, 33, 1);
        drain();

        // UNROLL=4 instance: one MUL, latency in capturing edges
        in_valid4 = 1'b1;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        lat4 = 1;
        while (!out_valid4 && lat4 < 60) begin
            @(posedge clk);
            #1;
            lat4++;
        end
        check("u4_latency", 64'(lat4), 64'd9);
        check("u4_result", 64'(out_result4), 64'hFFFF_FFEB);
        check("u4_tag", 64'(out_tag4), 64'd5);

        repeat (3) @(posedge clk);
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
